// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg: shared constants, channel index type and slice helper for the 1-to-4 stream demux
package stream_demux_pkg;
   localparam int N_CH  = 4;
   localparam int SEL_W = 2;
   typedef logic [SEL_W-1:0] ch_idx_t;
   function automatic int slice_off(input int i, input int w);
      return i * w;
   endfunction
endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry output register slice with load/drain control and optional drain counter (STREAM_DEMUX_CNT_EN)
module demux_slot #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             ready_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o
`ifdef STREAM_DEMUX_CNT_EN
   ,output logic [CNT_W-1:0] cnt_o
`endif
);
   logic             full_q, full_d;
   logic [WIDTH-1:0] data_q, data_d;
   // a load wins over a drain so the slot sustains one beat per cycle
   always_comb begin
      full_d = load_i ? 1'b1 : (full_q & ready_i) ? 1'b0 : full_q;
      data_d = load_i ? data_i : data_q;
   end
   // slot state; a beat held at reset is discarded
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
      end
   end
   assign valid_o = full_q;
   assign data_o  = data_q;
`ifdef STREAM_DEMUX_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;
   // count drain handshakes, wrapping at the counter width
   always_comb cnt_d = (full_q & ready_i) ? cnt_q + 1'b1 : cnt_q;
   // counter register, cleared only by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
   assign cnt_o = cnt_q;
`endif
endmodule

// File: rtl/stream_demux_1to4.sv
// stream_demux_1to4: registered 1-to-4 valid/ready demux with per-lane slots; beat counters under STREAM_DEMUX_CNT_EN
module stream_demux_1to4
   import stream_demux_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [WIDTH-1:0]        in_data,
   input  ch_idx_t                 in_sel,
   output logic [N_CH-1:0]         out_valid,
   input  logic [N_CH-1:0]         out_ready,
   output logic [N_CH*WIDTH-1:0]   out_data
`ifdef STREAM_DEMUX_CNT_EN
   ,output logic [N_CH*CNT_W-1:0]  beat_cnt
`endif
);
   logic [N_CH-1:0] load;
   // selected lane accepts when empty or draining this cycle (out_ready feeds in_ready combinationally)
   always_comb begin
      in_ready = ~out_valid[in_sel] | out_ready[in_sel];
      load     = (in_valid & in_ready) ? N_CH'(1) << in_sel : '0;
   end
   for (genvar i = 0; i < N_CH; i++) begin : g_slot
      demux_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot (
         .clk     (clk),
         .rst_n   (rst_n),
         .load_i  (load[i]),
         .data_i  (in_data),
         .ready_i (out_ready[i]),
         .valid_o (out_valid[i]),
         .data_o  (out_data[slice_off(i, WIDTH) +: WIDTH])
`ifdef STREAM_DEMUX_CNT_EN
         ,.cnt_o  (beat_cnt[slice_off(i, CNT_W) +: CNT_W])
`endif
      );
   end
endmodule

// File: doc/stream_demux_1to4.md
Name: stream_demux_1to4

Overview:
- Registered 1-to-4 stream demultiplexer: the inverse of the team's 4:1 select mux.
- Accepts one valid/ready input stream carrying a 2-bit route select per beat.
- Delivers each beat to exactly one of four independent valid/ready output channels through a one-entry register slot per channel.
- Sits between a shared producer and four per-lane consumers. Lanes stall independently, so a blocked lane never blocks beats routed to other lanes.

Parameters:
- WIDTH, 8, data bits per beat.
- CNT_W, 16, width of per-channel beat counters (used only with the optional feature).

Ports:
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  asynchronous active-low reset; assertion is asynchronous, deassertion is synchronous to clk.
- in_valid  input  1  input beat present.
- in_ready  output  1  input beat accepted this cycle when high together with in_valid.
- in_data  input  WIDTH  input payload.
- in_sel  input  2  destination channel 0..3; must be held stable while in_valid is high and not yet accepted.
- out_valid  output  4  bit i: channel i holds a beat.
- out_ready  input  4  bit i: consumer i takes the beat.
- out_data  output  4*WIDTH  channel i payload at bits [i*WIDTH +: WIDTH].
- beat_cnt  output  4*CNT_W  per-channel delivered-beat counters; exists only with STREAM_DEMUX_CNT_EN.

Behaviour:
- State per channel i: full[i] and data_q[i].
  - out_valid[i] = full[i].
  - out_data slice i = data_q[i].
- Reset (async, rst_n=0): full=4'b0000, all data_q=0, all beat_cnt=0. A beat in flight at reset is discarded; no partial delivery.
- in_ready = ~full[in_sel] | out_ready[in_sel].
  - Combinational path from out_ready to in_ready is permitted and documented.
  - There is no combinational path from in_valid/in_data to any out_* signal.
- Accept (in_valid & in_ready): data_q[in_sel] <= in_data; full[in_sel] <= 1 at the next edge. Latency from input accept to out_valid is exactly 1 cycle.
- Drain (full[i] & out_ready[i]): full[i] <= 0, unless the same channel is loaded in the same cycle, in which case full stays 1 and data_q takes the new beat. This allows one beat per cycle sustained per channel.
- Non-selected channels drain independently in the same cycle as an accept on another channel.
- When full[in_sel]=1 and out_ready[in_sel]=0: in_ready=0 and the input stalls. Other channels are unaffected but get no new input until the head beat moves. The input is strictly in-order.
- out_ready[i] while full[i]=0: ignored.
- out_valid[i] must stay high and data_q[i] stable until out_ready[i]=1 (standard valid/ready persistence).
- in_valid=0: in_sel and in_data are don't-care; no state change apart from drains.
- No beat is ever duplicated, dropped or reordered within a channel.

Optional Feature:
- Macro: STREAM_DEMUX_CNT_EN.
- Defined:
  - beat_cnt port exists.
  - Counter i increments by 1 on each drain handshake of channel i (full[i] & out_ready[i]).
  - Each counter is CNT_W bits and wraps from 2^CNT_W-1 to 0 without saturation.
  - Counters reset to 0 only on rst_n.
- Not defined: no beat_cnt port, no counter flops; all other behaviour is identical.

Decomposition:
- Package stream_demux_pkg holds:
  - N_CH=4 and SEL_W=2.
  - Localparam helper for slice offset i*WIDTH.
  - Channel index type (2-bit).
- Sub-module demux_slot: one-entry register slice holding full flag, data register, load/drain logic and the optional counter. It is instantiated 4x via generate. The top holds only the in_ready select and load-enable decode.

Test Plan:
1. Reset: assert rst_n=0 mid-transfer with channel 2 full -> out_valid=0000, out_data=0, beat_cnt=0 immediately (async); first beat after release delivered normally.
2. Single route: in_data=8'hA5, in_sel=2, all out_ready=1 -> next cycle out_valid=0100, channel 2 data=8'hA5; following cycle out_valid=0000.
3. Back-to-back, same channel: stream 8'h01..8'h10 to sel=1 with out_ready[1]=1 -> in_ready held 1, 16 beats out in order at 1 beat/cycle.
4. Stall isolation: out_ready[0]=0; send 8'h11 to ch0, 8'h22 to ch0 -> second stalls with in_ready=0. Then send 8'h33 to ch3 only after ch0 released -> ch0 shows 8'h11 until ready, no loss.
5. Simultaneous load+drain: ch1 full with 8'h44, out_ready[1]=1, input 8'h55 sel=1 -> same cycle accept; next cycle out_valid[1]=1 with 8'h55.
6. With STREAM_DEMUX_CNT_EN and CNT_W=4: deliver 17 beats to ch3 -> beat_cnt ch3 = 1 (wrapped), others 0.
